// File: rtl/ray_unit_sequencer.sv
// ray_unit_sequencer: queues rays and marches each one through lookup/step cycles until hit, exit or step budget, then writes its pixel.
// Ports:
//   clk_i, rst_ni                 clock (rising edge), asynchronous active-low reset
//   ray_*                         ray input handshake and payload {q, v, pixel address}
//   traverse_*                    tree lookup request at the current position
//   result_*                      lookup result strobe, material (0 = empty) and leaf depth
//   step_*                        stepper request {q, v, cell lower/upper bound} and its result
//   write_*                       pixel write handshake
//   busy_o, queue_count_o         activity and queue occupancy
//   ray_done_o, ray_hit_o         one-cycle completion pulse and hit flag
module ray_unit_sequencer #(
  parameter int POSITION_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int ADDRESS_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int MAX_STEPS = 255,
  parameter logic [DATA_WIDTH-1:0] BACKGROUND = '0,
  localparam int DEPTH_WIDTH = $clog2(POSITION_WIDTH) + 1,
  localparam int COUNT_WIDTH = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ray_valid_i,
  output logic                        ray_ready_o,
  input  logic [3*POSITION_WIDTH-1:0] ray_q_i,
  input  logic [3*POSITION_WIDTH-1:0] ray_v_i,
  input  logic [ADDRESS_WIDTH-1:0]    ray_pixel_address_i,
  output logic                        traverse_valid_o,
  input  logic                        traverse_ready_i,
  output logic [3*POSITION_WIDTH-1:0] traverse_position_o,
  input  logic                        result_valid_i,
  input  logic [DATA_WIDTH-1:0]       result_material_i,
  input  logic [DEPTH_WIDTH-1:0]      result_depth_i,
  output logic                        step_valid_o,
  input  logic                        step_ready_i,
  output logic [3*POSITION_WIDTH-1:0] step_q_o,
  output logic [3*POSITION_WIDTH-1:0] step_v_o,
  output logic [3*POSITION_WIDTH-1:0] step_l_o,
  output logic [3*POSITION_WIDTH-1:0] step_u_o,
  input  logic                        step_done_i,
  input  logic [3*POSITION_WIDTH-1:0] step_qp_i,
  input  logic                        step_out_of_bounds_i,
  output logic                        write_valid_o,
  input  logic                        write_ready_i,
  output logic [ADDRESS_WIDTH-1:0]    write_address_o,
  output logic [DATA_WIDTH-1:0]       write_data_o,
  output logic                        busy_o,
  output logic [COUNT_WIDTH-1:0]      queue_count_o,
  output logic                        ray_done_o,
  output logic                        ray_hit_o
);
  localparam int PW = POSITION_WIDTH;
  localparam int VW = 3 * PW;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int ENTRY_W = 2 * VW + ADDRESS_WIDTH;
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [DEPTH_WIDTH-1:0] PW_D = DEPTH_WIDTH'(PW);
  typedef enum logic [2:0] {IDLE, TRAVERSE_REQ, TRAVERSE_WAIT, STEP_REQ, STEP_WAIT, WRITE} state_e;
  state_e state_q, state_d;
  logic [ENTRY_W-1:0] mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic push, pop;
  logic [VW-1:0] q_q, q_d, v_q, v_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d, shamt;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic hit_q, hit_d, done_q, done_d, done_hit_q, done_hit_d;
  logic [PW-1:0] mask;
  // ready is gated by reset so nothing is offered while the block is held in reset
  assign ray_ready_o = rst_ni && (count_q < COUNT_WIDTH'(QUEUE_DEPTH));
  assign push = ray_valid_i && ray_ready_o;
  assign pop = (state_q == IDLE) && (count_q != '0);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) mem_q[wr_ptr_q] <= {ray_q_i, ray_v_i, ray_pixel_address_i};
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    v_d = v_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    depth_d = depth_q;
    data_d = data_q;
    hit_d = hit_q;
    done_d = 1'b0;
    done_hit_d = 1'b0;
    unique case (state_q)
      IDLE: if (pop) begin
        {q_d, v_d, addr_d} = mem_q[rd_ptr_q];
        cnt_d = '0;
        state_d = TRAVERSE_REQ;
      end
      TRAVERSE_REQ: state_d = traverse_ready_i ? TRAVERSE_WAIT : TRAVERSE_REQ;
      TRAVERSE_WAIT: if (result_valid_i) begin
        depth_d = result_depth_i;
        if (result_material_i != '0) begin
          data_d = result_material_i;
          hit_d = 1'b1;
          state_d = WRITE;
        end else if (cnt_q == STEP_W'(MAX_STEPS)) begin
          data_d = BACKGROUND;
          hit_d = 1'b0;
          state_d = WRITE;
        end else state_d = STEP_REQ;
      end
      STEP_REQ: state_d = step_ready_i ? STEP_WAIT : STEP_REQ;
      STEP_WAIT: if (step_done_i) begin
        if (step_out_of_bounds_i) begin
          data_d = BACKGROUND;
          hit_d = 1'b0;
          state_d = WRITE;
        end else begin
          q_d = step_qp_i;
          cnt_d = cnt_q + STEP_W'(1);
          state_d = TRAVERSE_REQ;
        end
      end
      WRITE: if (write_ready_i) begin
        state_d = IDLE;
        done_d = 1'b1;
        done_hit_d = hit_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      q_q <= '0;
      v_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      depth_q <= '0;
      data_q <= '0;
      hit_q <= 1'b0;
      done_q <= 1'b0;
      done_hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      v_q <= v_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      depth_q <= depth_d;
      data_q <= data_d;
      hit_q <= hit_d;
      done_q <= done_d;
      done_hit_q <= done_hit_d;
    end
  // cell size mask built one bit wider so depth 0 yields all ones after truncation
  assign shamt = PW_D - depth_q;
  assign mask = PW'(({{PW{1'b0}}, 1'b1} << shamt) - {{PW{1'b0}}, 1'b1});
  assign traverse_valid_o = state_q == TRAVERSE_REQ;
  assign traverse_position_o = q_q;
  assign step_valid_o = state_q == STEP_REQ;
  assign step_q_o = q_q;
  assign step_v_o = v_q;
  assign step_l_o = q_q & ~{3{mask}};
  assign step_u_o = q_q | {3{mask}};
  assign write_valid_o = state_q == WRITE;
  assign write_address_o = addr_q;
  assign write_data_o = data_q;
  assign busy_o = (count_q != '0) || (state_q != IDLE);
  assign queue_count_o = count_q;
  assign ray_done_o = done_q;
  assign ray_hit_o = done_hit_q;
endmodule

// File: tb/tb_ray_unit_sequencer.sv
// tb_ray_unit_sequencer: directed self-checking bench for ray_unit_sequencer.
module tb_ray_unit_sequencer;
  localparam logic [23:0] BG = 24'h5A5A5A;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ray_valid = 1'b0, ray_ready;
  logic [47:0] ray_q = '0, ray_v = '0;
  logic [31:0] ray_addr = '0;
  logic traverse_valid, traverse_ready = 1'b0;
  logic [47:0] traverse_position;
  logic result_valid = 1'b0;
  logic [23:0] result_material = '0;
  logic [4:0] result_depth = '0;
  logic step_valid, step_ready = 1'b0;
  logic [47:0] step_q, step_v, step_l, step_u;
  logic step_done = 1'b0;
  logic [47:0] step_qp = '0;
  logic step_oob = 1'b0;
  logic write_valid, write_ready = 1'b0;
  logic [31:0] write_address;
  logic [23:0] write_data;
  logic busy;
  logic [2:0] queue_count;
  logic ray_done, ray_hit;
  int tests = 0, fails = 0;
  int n_wr = 0, n_trav = 0, n_step = 0, n_done = 0;
  ray_unit_sequencer #(.MAX_STEPS(3), .BACKGROUND(BG)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ray_valid_i(ray_valid), .ray_ready_o(ray_ready),
    .ray_q_i(ray_q), .ray_v_i(ray_v), .ray_pixel_address_i(ray_addr),
    .traverse_valid_o(traverse_valid), .traverse_ready_i(traverse_ready),
    .traverse_position_o(traverse_position),
    .result_valid_i(result_valid), .result_material_i(result_material), .result_depth_i(result_depth),
    .step_valid_o(step_valid), .step_ready_i(step_ready),
    .step_q_o(step_q), .step_v_o(step_v), .step_l_o(step_l), .step_u_o(step_u),
    .step_done_i(step_done), .step_qp_i(step_qp), .step_out_of_bounds_i(step_oob),
    .write_valid_o(write_valid), .write_ready_i(write_ready),
    .write_address_o(write_address), .write_data_o(write_data),
    .busy_o(busy), .queue_count_o(queue_count),
    .ray_done_o(ray_done), .ray_hit_o(ray_hit)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (write_valid && write_ready) n_wr <= n_wr + 1;
    if (traverse_valid && traverse_ready) n_trav <= n_trav + 1;
    if (step_valid && step_ready) n_step <= n_step + 1;
    if (ray_done) n_done <= n_done + 1;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, need finish)");
    $fatal(1, "watchdog");
  end
  task automatic wait_valid(input int which, input string what);
    int k = 0;
    while (k < 200 && !(which == 0 ? traverse_valid : which == 1 ? step_valid : write_valid)) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k == 200) begin
      fails++;
      $display("FAIL %s: valid never rose (got 0, need 1)", what);
    end
  endtask
  task automatic push_ray(input logic [47:0] q, input logic [47:0] v, input logic [31:0] a);
    int k = 0;
    ray_q = q;
    ray_v = v;
    ray_addr = a;
    ray_valid = 1'b1;
    while (k < 200 && !ray_ready) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k == 200) begin
      fails++;
      $display("FAIL push_ray: ray_ready never rose (got 0, need 1)");
    end
    @(negedge clk);
    ray_valid = 1'b0;
  endtask
  task automatic serve_traverse(input logic [23:0] mat, input logic [4:0] d, output logic [47:0] pos);
    wait_valid(0, "traverse_valid");
    pos = traverse_position;
    traverse_ready = 1'b1;
    @(negedge clk);
    traverse_ready = 1'b0;
    result_valid = 1'b1;
    result_material = mat;
    result_depth = d;
    @(negedge clk);
    result_valid = 1'b0;
  endtask
  task automatic serve_step(input logic oob, input logic [47:0] qp, output logic [47:0] l, output logic [47:0] u);
    wait_valid(1, "step_valid");
    l = step_l;
    u = step_u;
    step_ready = 1'b1;
    @(negedge clk);
    step_ready = 1'b0;
    step_done = 1'b1;
    step_oob = oob;
    step_qp = qp;
    @(negedge clk);
    step_done = 1'b0;
    step_oob = 1'b0;
  endtask
  task automatic accept_write(output logic [31:0] a, output logic [23:0] d);
    wait_valid(2, "write_valid");
    a = write_address;
    d = write_data;
    write_ready = 1'b1;
    @(negedge clk);
    write_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    ray_valid = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({traverse_valid, step_valid, write_valid, ray_ready, busy, ray_done, ray_hit} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, need 0000000", {traverse_valid, step_valid, write_valid, ray_ready, busy, ray_done, ray_hit});
    end
    tests++;
    if (queue_count !== 3'd0) begin
      fails++;
      $display("FAIL reset_count: got %0d, need 0", queue_count);
    end
    ray_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (ray_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%b busy=%b, need ready=1 busy=0", ray_ready, busy);
    end
  endtask
  task automatic test_hit();
    logic [47:0] pos;
    logic [31:0] a;
    logic [23:0] d;
    int s = n_step, t = n_trav, w = n_wr;
    push_ray({16'd5, 16'd5, 16'd5}, {16'd0, 16'd0, 16'd1}, 32'h100);
    tests++;
    if (traverse_valid !== 1'b0 || queue_count !== 3'd1) begin
      fails++;
      $display("FAIL hit_latency_n1: tv=%b count=%0d, need tv=0 count=1", traverse_valid, queue_count);
    end
    @(negedge clk);
    tests++;
    if (traverse_valid !== 1'b1 || traverse_position !== {16'd5, 16'd5, 16'd5} || queue_count !== 3'd0) begin
      fails++;
      $display("FAIL hit_latency_n2: tv=%b pos=%h count=%0d, need tv=1 pos=000500050005 count=0", traverse_valid, traverse_position, queue_count);
    end
    result_valid = 1'b1;
    result_material = 24'h999999;
    step_done = 1'b1;
    step_oob = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    step_done = 1'b0;
    step_oob = 1'b0;
    tests++;
    if (traverse_valid !== 1'b1 || write_valid !== 1'b0 || step_valid !== 1'b0) begin
      fails++;
      $display("FAIL hit_ignore_strobes: tv=%b wv=%b sv=%b, need 1 0 0", traverse_valid, write_valid, step_valid);
    end
    serve_traverse(24'h00ABCD, 5'd3, pos);
    accept_write(a, d);
    tests++;
    if (a !== 32'h100 || d !== 24'h00ABCD) begin
      fails++;
      $display("FAIL hit_write: addr=%h data=%h, need 00000100 00abcd", a, d);
    end
    tests++;
    if (ray_done !== 1'b1 || ray_hit !== 1'b1) begin
      fails++;
      $display("FAIL hit_done: done=%b hit=%b, need 1 1", ray_done, ray_hit);
    end
    tests++;
    if (n_step - s != 0 || n_trav - t != 1 || n_wr - w != 1) begin
      fails++;
      $display("FAIL hit_counts: steps=%0d lookups=%0d writes=%0d, need 0 1 1", n_step - s, n_trav - t, n_wr - w);
    end
    @(negedge clk);
    tests++;
    if (ray_done !== 1'b0) begin
      fails++;
      $display("FAIL hit_done_pulse: done=%b, need 0", ray_done);
    end
  endtask
  task automatic test_step_exit();
    logic [47:0] pos, l, u;
    logic [31:0] a;
    logic [23:0] d;
    push_ray({16'h0, 16'h0, 16'h1234}, {16'h0, 16'h0, 16'h1}, 32'h180);
    serve_traverse(24'h0, 5'd2, pos);
    serve_step(1'b1, 48'h0, l, u);
    tests++;
    if (l !== 48'h0 || u !== {3{16'h3FFF}}) begin
      fails++;
      $display("FAIL step_exit_bounds: L=%h U=%h, need 000000000000 3fff3fff3fff", l, u);
    end
    accept_write(a, d);
    tests++;
    if (a !== 32'h180 || d !== BG || ray_done !== 1'b1 || ray_hit !== 1'b0) begin
      fails++;
      $display("FAIL step_exit_write: addr=%h data=%h done=%b hit=%b, need 00000180 %h 1 0", a, d, ray_done, ray_hit, BG);
    end
  endtask
  task automatic test_budget();
    logic [47:0] pos, l, u;
    logic [31:0] a;
    logic [23:0] d;
    logic [47:0] qs [4];
    logic [47:0] el [3];
    logic [47:0] eu [3];
    logic [4:0] dep [3];
    int s = n_step, t = n_trav;
    qs[0] = {16'h8000, 16'hFFFF, 16'h1234};
    qs[1] = {16'h0001, 16'h0002, 16'h0003};
    qs[2] = {16'hABCD, 16'h1234, 16'h5678};
    qs[3] = {16'h0010, 16'h0020, 16'h0030};
    dep[0] = 5'd0;
    dep[1] = 5'd16;
    dep[2] = 5'd4;
    el[0] = 48'h0;
    eu[0] = 48'hFFFF_FFFF_FFFF;
    el[1] = qs[1];
    eu[1] = qs[1];
    el[2] = {16'hA000, 16'h1000, 16'h5000};
    eu[2] = {16'hAFFF, 16'h1FFF, 16'h5FFF};
    push_ray(qs[0], 48'h1, 32'h1C0);
    for (int i = 0; i < 3; i++) begin
      serve_traverse(24'h0, dep[i], pos);
      tests++;
      if (pos !== qs[i]) begin
        fails++;
        $display("FAIL budget_pos%0d: got %h, need %h", i, pos, qs[i]);
      end
      serve_step(1'b0, qs[i+1], l, u);
      tests++;
      if (l !== el[i] || u !== eu[i]) begin
        fails++;
        $display("FAIL budget_bounds%0d: L=%h U=%h, need %h %h", i, l, u, el[i], eu[i]);
      end
    end
    serve_traverse(24'h0, 5'd5, pos);
    tests++;
    if (pos !== qs[3]) begin
      fails++;
      $display("FAIL budget_pos3: got %h, need %h", pos, qs[3]);
    end
    accept_write(a, d);
    tests++;
    if (d !== BG || ray_hit !== 1'b0 || n_step - s != 3 || n_trav - t != 4) begin
      fails++;
      $display("FAIL budget_result: data=%h hit=%b steps=%0d lookups=%0d, need %h 0 3 4", d, ray_hit, n_step - s, n_trav - t, BG);
    end
  endtask
  task automatic test_back_to_back();
    logic [47:0] pos;
    logic [31:0] a;
    logic [23:0] d;
    for (int i = 0; i < 5; i++) begin
      ray_q = {3{16'(i)}};
      ray_addr = 32'h200 + 32'(i);
      ray_valid = 1'b1;
      tests++;
      if (ray_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready%0d: got %b, need 1", i, ray_ready);
      end
      @(negedge clk);
    end
    ray_valid = 1'b0;
    tests++;
    if (queue_count !== 3'd4 || ray_ready !== 1'b0 || traverse_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_full: count=%0d ready=%b tv=%b, need 4 0 1", queue_count, ray_ready, traverse_valid);
    end
    ray_addr = 32'h2FF;
    ray_valid = 1'b1;
    @(negedge clk);
    ray_valid = 1'b0;
    tests++;
    if (queue_count !== 3'd4) begin
      fails++;
      $display("FAIL b2b_reject: count=%0d, need 4", queue_count);
    end
    for (int i = 0; i < 5; i++) begin
      serve_traverse(24'h000100 + 24'(i), 5'd0, pos);
      tests++;
      if (pos !== {3{16'(i)}}) begin
        fails++;
        $display("FAIL b2b_pos%0d: got %h, need %h", i, pos, {3{16'(i)}});
      end
      accept_write(a, d);
      tests++;
      if (a !== 32'h200 + 32'(i) || d !== 24'h000100 + 24'(i)) begin
        fails++;
        $display("FAIL b2b_order%0d: addr=%h data=%h, need %h %h", i, a, d, 32'h200 + 32'(i), 24'h000100 + 24'(i));
      end
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || queue_count !== 3'd0) begin
      fails++;
      $display("FAIL b2b_drain: busy=%b count=%0d, need 0 0", busy, queue_count);
    end
  endtask
  task automatic test_held_write();
    logic [47:0] pos;
    int dn;
    push_ray({16'h7, 16'h8, 16'h9}, 48'h1, 32'h300);
    serve_traverse(24'h777777, 5'd1, pos);
    wait_valid(2, "held_write_valid");
    dn = n_done;
    for (int c = 0; c < 10; c++) begin
      tests++;
      if (write_valid !== 1'b1 || write_address !== 32'h300 || write_data !== 24'h777777 || ray_done !== 1'b0) begin
        fails++;
        $display("FAIL held_write%0d: wv=%b addr=%h data=%h done=%b, need 1 00000300 777777 0", c, write_valid, write_address, write_data, ray_done);
      end
      @(negedge clk);
    end
    write_ready = 1'b1;
    @(negedge clk);
    write_ready = 1'b0;
    tests++;
    if (ray_done !== 1'b1 || ray_hit !== 1'b1 || write_valid !== 1'b0) begin
      fails++;
      $display("FAIL held_done: done=%b hit=%b wv=%b, need 1 1 0", ray_done, ray_hit, write_valid);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (n_done - dn != 1) begin
      fails++;
      $display("FAIL held_single_pulse: pulses=%0d, need 1", n_done - dn);
    end
  endtask
  task automatic test_reset_mid();
    logic [47:0] pos;
    int w, t;
    push_ray(48'h1, 48'h1, 32'h400);
    push_ray(48'h2, 48'h1, 32'h401);
    push_ray(48'h3, 48'h1, 32'h402);
    serve_traverse(24'h0, 5'd1, pos);
    wait_valid(1, "mid_step_valid");
    step_ready = 1'b1;
    @(negedge clk);
    step_ready = 1'b0;
    tests++;
    if (queue_count !== 3'd2 || busy !== 1'b1 || step_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_setup: count=%0d busy=%b sv=%b, need 2 1 0", queue_count, busy, step_valid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({traverse_valid, step_valid, write_valid, ray_ready, busy, ray_done, ray_hit} !== 7'b0 || queue_count !== 3'd0) begin
      fails++;
      $display("FAIL mid_reset: flags=%b count=%0d, need 0000000 0", {traverse_valid, step_valid, write_valid, ray_ready, busy, ray_done, ray_hit}, queue_count);
    end
    w = n_wr;
    t = n_trav;
    @(negedge clk);
    rst_n = 1'b1;
    step_done = 1'b1;
    step_oob = 1'b1;
    write_ready = 1'b1;
    traverse_ready = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    step_oob = 1'b0;
    tests++;
    if (ray_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_ready: got %b, need 1", ray_ready);
    end
    repeat (20) @(negedge clk);
    write_ready = 1'b0;
    traverse_ready = 1'b0;
    tests++;
    if (n_wr - w != 0 || n_trav - t != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_no_write: writes=%0d lookups=%0d busy=%b, need 0 0 0", n_wr - w, n_trav - t, busy);
    end
  endtask
  initial begin
    test_reset();
    test_hit();
    test_step_exit();
    test_budget();
    test_back_to_back();
    test_held_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ray_unit_sequencer.md
RAY_UNIT_SEQUENCER -- requirements
Module: ray_unit_sequencer

Interface
REQ-001 SHALL have parameter POSITION_WIDTH, default 16, bits per coordinate.
REQ-002 SHALL have parameter DATA_WIDTH, default 24, material/pixel width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32, pixel address width.
REQ-004 SHALL have parameter QUEUE_DEPTH, default 4, ray queue entries (power of two, >=2).
REQ-005 SHALL have parameter MAX_STEPS, default 255, step budget per ray (>=1).
REQ-006 SHALL have parameter BACKGROUND, default 0, pixel written on miss or budget exhaustion.
REQ-007 SHALL have derived DEPTH_WIDTH = clog2(POSITION_WIDTH)+1.
REQ-008 SHALL have ports, in order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- rayValid/rayReady  in/out  1/1  ray input handshake.
- rayQ, rayV  in  3 x POSITION_WIDTH  ray origin, direction.
- rayPixelAddress  in  ADDRESS_WIDTH  destination of ray's pixel.
- traverseValid/traverseReady  out/in  1/1  tree lookup request.
- traversePosition  out  3 x POSITION_WIDTH  current q.
- resultValid  in  1  lookup result strobe.
- resultMaterial  in  DATA_WIDTH  0 = empty voxel.
- resultDepth  in  DEPTH_WIDTH  tree depth of leaf, 0..POSITION_WIDTH.
- stepValid/stepReady  out/in  1/1  stepper request.
- stepQ, stepV, stepL, stepU  out  3 x POSITION_WIDTH  stepper operands.
- stepDone  in  1  stepper result strobe.
- stepQp  in  3 x POSITION_WIDTH  next position.
- stepOutOfBounds  in  1  ray left scene.
- writeValid/writeReady  out/in  1/1  pixel write handshake.
- writeAddress  out  ADDRESS_WIDTH; writeData  out  DATA_WIDTH.
- busy  out  1  queue non-empty or FSM not IDLE.
- queueCount  out  clog2(QUEUE_DEPTH)+1  occupied entries.
- rayDone  out  1  one-cycle pulse per finished ray.
- rayHit  out  1  valid with rayDone; 1 = non-zero material found.

Function
REQ-009 Queue SHALL be FIFO; rayReady = (queueCount < QUEUE_DEPTH); push on rayValid & rayReady stores {rayQ, rayV, rayPixelAddress}.
REQ-010 Simultaneous push and pop SHALL leave queueCount unchanged; no bypass: a ray pushed into an empty queue at edge N pops at edge N+1; traverseValid high from cycle N+2.
REQ-011 FSM states SHALL be IDLE, TRAVERSE_REQ, TRAVERSE_WAIT, STEP_REQ, STEP_WAIT, WRITE.
REQ-012 IDLE: if queue non-empty, pop, load q, v, address, stepCount=0 -> TRAVERSE_REQ.
REQ-013 TRAVERSE_REQ: traverseValid=1, traversePosition=q; on traverseReady -> TRAVERSE_WAIT.
REQ-014 TRAVERSE_WAIT: on resultValid latch resultDepth; material!=0 -> WRITE, data=material, hit=1; else stepCount==MAX_STEPS -> WRITE, data=BACKGROUND, hit=0; else -> STEP_REQ.
REQ-015 STEP_REQ: stepValid=1; mask = (1<<(POSITION_WIDTH-depth))-1 computed at POSITION_WIDTH+1 bits then truncated (depth 0 -> all ones); stepL[i]=q[i]&~mask, stepU[i]=q[i]|mask; on stepReady -> STEP_WAIT.
REQ-016 STEP_WAIT: on stepDone: stepOutOfBounds -> WRITE, data=BACKGROUND, hit=0; else q<=stepQp, stepCount+1 -> TRAVERSE_REQ.
REQ-017 WRITE: writeValid=1; on writeReady -> IDLE, rayDone=1 and rayHit for exactly the following cycle.
REQ-018 All request payloads SHALL be stable while their valid is high; valid SHALL not drop before ready.
REQ-019 resultValid/stepDone outside their WAIT state SHALL be ignored.
REQ-020 stepCount width SHALL be clog2(MAX_STEPS+1); never wraps.

Reset
REQ-021 reset low SHALL immediately force state IDLE, queue empty, queueCount 0, all valid outputs 0, rayDone 0, rayHit 0, busy 0, rayReady 0.
REQ-022 Reset mid-ray SHALL drop the ray and all queued rays with no write; rayReady 1 the first cycle after reset deasserts.

Verification
REQ-023 Hit on first lookup: push q=(5,5,5); result material=0x00ABCD -> one write, data 0x00ABCD, rayDone with rayHit=1, zero step requests.
REQ-024 Step then exit: empty result depth 2, q=(0x1234,0,0) -> stepL[0]=0x0000, stepU[0]=0x3FFF; stepOutOfBounds=1 -> write BACKGROUND, rayHit=0.
REQ-025 Budget: MAX_STEPS=3, all results empty, never out of bounds -> exactly 3 steps, 4 lookups, write BACKGROUND.
REQ-026 Backpressure: push 5 rays with traverseReady=0 -> rayReady falls after 4 accepted (first popped into FSM, queueCount=4); writes occur in push order.
REQ-027 Reset asserted in STEP_WAIT with 2 rays queued -> all valids 0 same cycle, queueCount 0, no subsequent write.
REQ-028 Held handshakes: writeReady low 10 cycles -> writeValid, writeAddress, writeData constant; single rayDone pulse after acceptance.
